// File: rtl/eu_demux_pkg.sv
// Shared types and address-field constants for the event-unit request crossbar.
package eu_demux_pkg;

  typedef enum logic [1:0] {
    TGT_CORE = 2'd0,
    TGT_BARR = 2'd1,
    TGT_ERR  = 2'd2
  } tgt_e;

  localparam int          SEL_BIT       = 9;
  localparam logic [2:0]  TRIG_A        = 3'd5;
  localparam logic [2:0]  TRIG_B        = 3'd6;
  localparam logic [2:0]  TRIG_C        = 3'd7;
  localparam int          BIDX_LSB      = 5;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hBADACCE5;

endpackage

// File: rtl/eu_rr_arbiter.sv
// Per-barrier arbiter over all cores. Round-robin when EU_BARR_RR_ARB_EN is
// defined, otherwise fixed priority with the lowest core index winning.
module eu_rr_arbiter #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          hs_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic [IW-1:0] ptr_o
);

  logic          found;
  logic [IW-1:0] start;
  logic [IW-1:0] cand;

`ifdef EU_BARR_RR_ARB_EN
  logic [IW-1:0] rr_q;

  // Pointer moves just past the winner, and only on an accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (hs_i) begin
      rr_q <= gnt_idx_o + IW'(1);
    end
  end

  assign start = rr_q;
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk_i, rst_ni, hs_i};
  assign start        = '0;
`endif

  assign ptr_o = start;

  // N is a power of two, so the IW-bit add wraps the search modulo N.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    gnt_oh_o  = '0;
    for (int o = 0; o < N; o++) begin
      cand = start + IW'(o);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (found) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/eu_demux_xbar.sv
// Event-unit request crossbar: routes each core to its private slice or to a
// shared barrier unit. Barrier arbitration style is selected by EU_BARR_RR_ARB_EN.
module eu_demux_xbar
  import eu_demux_pkg::*;
#(
  parameter  int          NB_CORES   = 8,
  parameter  int          NB_BARR    = 4,
  parameter  int          BARR_IDX_W = 4,
  parameter  logic [31:0] ERR_RDATA  = ERR_RDATA_DEF,
  localparam int          CIW        = $clog2(NB_CORES)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NB_CORES-1:0]             core_req_i,
  input  logic [NB_CORES-1:0][31:0]       core_add_i,
  input  logic [NB_CORES-1:0]             core_wen_i,
  input  logic [NB_CORES-1:0][31:0]       core_wdata_i,
  output logic [NB_CORES-1:0]             core_gnt_o,
  output logic [NB_CORES-1:0]             core_r_valid_o,
  output logic [NB_CORES-1:0][31:0]       core_r_rdata_o,
  output logic [NB_CORES-1:0]             core_r_opc_o,
  output logic [NB_CORES-1:0]             cu_req_o,
  output logic [NB_CORES-1:0][31:0]       cu_add_o,
  output logic [NB_CORES-1:0]             cu_wen_o,
  output logic [NB_CORES-1:0][31:0]       cu_wdata_o,
  input  logic [NB_CORES-1:0]             cu_gnt_i,
  input  logic [NB_CORES-1:0]             cu_r_valid_i,
  input  logic [NB_CORES-1:0][31:0]       cu_r_rdata_i,
  output logic [NB_BARR-1:0]              bu_req_o,
  output logic [NB_BARR-1:0][31:0]        bu_add_o,
  output logic [NB_BARR-1:0]              bu_wen_o,
  output logic [NB_BARR-1:0][31:0]        bu_wdata_o,
  input  logic [NB_BARR-1:0]              bu_gnt_i,
  input  logic [NB_BARR-1:0]              bu_r_valid_i,
  input  logic [NB_BARR-1:0][31:0]        bu_r_rdata_i,
  output logic [NB_BARR-1:0][CIW-1:0]     dbg_rr_ptr_o
);

  // Handshake: a request is accepted in the cycle where req and gnt are both
  // high; req must stay stable until then, and r_valid follows one cycle later.

  tgt_e                                tgt_d [NB_CORES];
  logic [NB_CORES-1:0][BARR_IDX_W-1:0] bidx_d;
  logic [NB_BARR-1:0][NB_CORES-1:0]    breq;
  logic [NB_BARR-1:0][NB_CORES-1:0]    boh;
  logic [NB_BARR-1:0][CIW-1:0]         bwin;
  logic [NB_CORES-1:0]                 bu_gnt_core;
  logic [NB_CORES-1:0]                 hs;

  tgt_e                                rsp_tgt_q [NB_CORES];
  logic [NB_CORES-1:0]                 rsp_pend_q;
  logic [NB_CORES-1:0][BARR_IDX_W-1:0] rsp_bidx_q;

  always_comb begin
    for (int i = 0; i < NB_CORES; i++) begin
      bidx_d[i] = core_add_i[i][BIDX_LSB +: BARR_IDX_W];
      if (!core_add_i[i][SEL_BIT] || (core_add_i[i][4:2] inside {TRIG_A, TRIG_B, TRIG_C})) begin
        tgt_d[i] = TGT_CORE;
      end else if (int'(bidx_d[i]) >= NB_BARR) begin
        tgt_d[i] = TGT_ERR;
      end else begin
        tgt_d[i] = TGT_BARR;
      end
    end
  end

  always_comb begin
    breq = '0;
    for (int b = 0; b < NB_BARR; b++) begin
      for (int i = 0; i < NB_CORES; i++) begin
        breq[b][i] = core_req_i[i] && (tgt_d[i] == TGT_BARR) && (int'(bidx_d[i]) == b);
      end
    end
  end

  for (genvar b = 0; b < NB_BARR; b++) begin : g_barr
    eu_rr_arbiter #(.N(NB_CORES)) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (breq[b]),
      .hs_i      (bu_req_o[b] & bu_gnt_i[b]),
      .gnt_oh_o  (boh[b]),
      .gnt_idx_o (bwin[b]),
      .ptr_o     (dbg_rr_ptr_o[b])
    );

    assign bu_req_o[b]   = |breq[b];
    assign bu_add_o[b]   = bu_req_o[b] ? core_add_i[bwin[b]]   : '0;
    assign bu_wen_o[b]   = bu_req_o[b] ? core_wen_i[bwin[b]]   : 1'b0;
    assign bu_wdata_o[b] = bu_req_o[b] ? core_wdata_i[bwin[b]] : '0;
  end

  assign cu_add_o   = core_add_i;
  assign cu_wen_o   = core_wen_i;
  assign cu_wdata_o = core_wdata_i;

  always_comb begin
    bu_gnt_core = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      for (int b = 0; b < NB_BARR; b++) begin
        bu_gnt_core[i] = bu_gnt_core[i] | (boh[b][i] & bu_gnt_i[b]);
      end
    end
  end

  // Decode errors are accepted immediately and never reach a downstream unit.
  always_comb begin
    for (int i = 0; i < NB_CORES; i++) begin
      cu_req_o[i] = core_req_i[i] && (tgt_d[i] == TGT_CORE);
      case (tgt_d[i])
        TGT_CORE: core_gnt_o[i] = cu_req_o[i] & cu_gnt_i[i];
        TGT_BARR: core_gnt_o[i] = bu_gnt_core[i];
        TGT_ERR:  core_gnt_o[i] = core_req_i[i];
        default:  core_gnt_o[i] = 1'b0;
      endcase
    end
  end

  assign hs = core_req_i & core_gnt_o;

  // A new acceptance reloads tracking even while the previous response drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_pend_q <= '0;
      rsp_bidx_q <= '0;
      for (int i = 0; i < NB_CORES; i++) rsp_tgt_q[i] <= TGT_CORE;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        if (hs[i]) begin
          rsp_pend_q[i] <= 1'b1;
          rsp_tgt_q[i]  <= tgt_d[i];
          rsp_bidx_q[i] <= bidx_d[i];
        end else if (core_r_valid_o[i]) begin
          rsp_pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    core_r_valid_o = '0;
    core_r_rdata_o = '0;
    core_r_opc_o   = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (rsp_pend_q[i]) begin
        case (rsp_tgt_q[i])
          TGT_CORE: begin
            core_r_valid_o[i] = cu_r_valid_i[i];
            core_r_rdata_o[i] = cu_r_rdata_i[i];
          end
          TGT_BARR: begin
            for (int b = 0; b < NB_BARR; b++) begin
              if (int'(rsp_bidx_q[i]) == b) begin
                core_r_valid_o[i] = bu_r_valid_i[b];
                core_r_rdata_o[i] = bu_r_rdata_i[b];
              end
            end
          end
          TGT_ERR: begin
            core_r_valid_o[i] = 1'b1;
            core_r_rdata_o[i] = ERR_RDATA;
            core_r_opc_o[i]   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eu_demux_xbar.sv
// Randomized scoreboard bench for eu_demux_xbar with behavioural downstream units.
module tb_eu_demux_xbar;

  localparam int NC = 8;
  localparam int NB = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]        core_req, core_wen, core_gnt, core_r_valid, core_r_opc;
  logic [NC-1:0][31:0]  core_add, core_wdata, core_r_rdata;
  logic [NC-1:0]        cu_req, cu_wen, cu_gnt;
  logic [NC-1:0][31:0]  cu_add, cu_wdata;
  logic [NC-1:0]        cu_r_valid = '0;
  logic [NC-1:0][31:0]  cu_r_rdata = '0;
  logic [NB-1:0]        bu_req, bu_wen, bu_gnt;
  logic [NB-1:0][31:0]  bu_add, bu_wdata;
  logic [NB-1:0]        bu_r_valid = '0;
  logic [NB-1:0][31:0]  bu_r_rdata = '0;
  logic [NB-1:0][IW-1:0] dbg_ptr;

  eu_demux_xbar #(.NB_CORES(NC), .NB_BARR(NB), .BARR_IDX_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_add_i(core_add), .core_wen_i(core_wen), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_r_valid_o(core_r_valid), .core_r_rdata_o(core_r_rdata), .core_r_opc_o(core_r_opc),
    .cu_req_o(cu_req), .cu_add_o(cu_add), .cu_wen_o(cu_wen), .cu_wdata_o(cu_wdata),
    .cu_gnt_i(cu_gnt), .cu_r_valid_i(cu_r_valid), .cu_r_rdata_i(cu_r_rdata),
    .bu_req_o(bu_req), .bu_add_o(bu_add), .bu_wen_o(bu_wen), .bu_wdata_o(bu_wdata),
    .bu_gnt_i(bu_gnt), .bu_r_valid_i(bu_r_valid), .bu_r_rdata_i(bu_r_rdata),
    .dbg_rr_ptr_o(dbg_ptr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ptr [NB];
  logic [32:0] exp_q [NC][$];
  int          due_q [NC][$];

  function automatic logic [31:0] core_data(input int i, input logic [31:0] a);
    return {8'hC5, 4'(i), 4'h0, a[15:0]};
  endfunction

  function automatic logic [31:0] barr_data(input int b, input logic [31:0] a);
    return {8'hBA, 4'(b), 4'h0, a[15:0]};
  endfunction

  // 0 = core slice, 1 = barrier, 2 = decode error
  function automatic int tgt_of(input logic [31:0] a);
    if (a[9] == 1'b0 || int'(a[4:2]) >= 5) return 0;
    if (int'(a[8:5]) >= NB) return 2;
    return 1;
  endfunction

  function automatic int bidx_of(input logic [31:0] a);
    return int'(a[8:5]);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int kind;
    a = $urandom;
    kind = $urandom_range(0, 3);
    a[31:16] = '0;
    a[1:0] = '0;
    case (kind)
      0: a[9] = 1'b0;
      1: begin a[9] = 1'b1; a[4:2] = 3'($urandom_range(5, 7)); end
      2: begin a[9] = 1'b1; a[4:2] = 3'($urandom_range(0, 4)); a[8:5] = 4'($urandom_range(0, NB-1)); end
      default: begin a[9] = 1'b1; a[4:2] = 3'($urandom_range(0, 4)); a[8:5] = 4'($urandom_range(NB, 15)); end
    endcase
    return a;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Downstream units: accept per gnt, answer exactly one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NC; i++) begin
      cu_r_valid[i] <= cu_req[i] & cu_gnt[i];
      cu_r_rdata[i] <= core_data(i, cu_add[i]);
    end
    for (int b = 0; b < NB; b++) begin
      bu_r_valid[b] <= bu_req[b] & bu_gnt[b];
      bu_r_rdata[b] <= barr_data(b, bu_add[b]);
    end
  end

  // Response monitor: pops the per-core expected queue whenever r_valid shows.
  always @(negedge clk) begin
    logic [32:0] e;
    int d;
    for (int i = 0; i < NC; i++) begin
      if (core_r_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected core %0d: got data %h opc %b, required no response", i, core_r_rdata[i], core_r_opc[i]);
        end else begin
          e = exp_q[i].pop_front();
          d = due_q[i].pop_front();
          check($sformatf("rsp_data core %0d", i), 64'({core_r_opc[i], core_r_rdata[i]}), 64'(e));
          check($sformatf("rsp_time core %0d", i), 64'(cyc), 64'(d));
        end
      end else if (exp_q[i].size() > 0 && due_q[i][0] <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_missing core %0d: got no r_valid, required %h", i, exp_q[i][0]);
        e = exp_q[i].pop_front();
        d = due_q[i].pop_front();
      end
    end
  end

  task automatic run_cycle(input logic [NC-1:0][31:0] adds, input logic [NC-1:0] req,
                           input logic [NC-1:0] cg, input logic [NB-1:0] bg,
                           output logic [NC-1:0] eg);
    int win [NB];
    int k;
    int tg;
    int bi;
    @(negedge clk);
    #1;
    core_add = adds;
    core_req = req;
    cu_gnt   = cg;
    bu_gnt   = bg;
    for (int i = 0; i < NC; i++) begin
      core_wen[i]   = adds[i][0];
      core_wdata[i] = ~adds[i];
    end
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      for (int o = 0; o < NC; o++) begin
`ifdef EU_BARR_RR_ARB_EN
        k = (ptr[b] + o) % NC;
`else
        k = o;
`endif
        if (win[b] < 0 && req[k] && tgt_of(adds[k]) == 1 && bidx_of(adds[k]) == b) win[b] = k;
      end
    end
    eg = '0;
    for (int i = 0; i < NC; i++) begin
      tg = tgt_of(adds[i]);
      if (tg == 0) eg[i] = req[i] & cg[i];
      else if (tg == 2) eg[i] = req[i];
      else begin
        bi = bidx_of(adds[i]);
        eg[i] = (win[bi] == i) && bg[bi];
      end
    end
    #1;
    check("core_gnt", 64'(core_gnt), 64'(eg));
    for (int i = 0; i < NC; i++)
      check($sformatf("cu_req %0d", i), 64'(cu_req[i]), 64'(req[i] && tgt_of(adds[i]) == 0));
    for (int b = 0; b < NB; b++) begin
      check($sformatf("bu_req %0d", b), 64'(bu_req[b]), 64'(win[b] >= 0));
      if (win[b] >= 0) check($sformatf("bu_add %0d", b), 64'(bu_add[b]), 64'(adds[win[b]]));
      check($sformatf("rr_ptr %0d", b), 64'(dbg_ptr[b]), 64'(ptr[b]));
    end
    for (int i = 0; i < NC; i++) begin
      if (eg[i]) begin
        tg = tgt_of(adds[i]);
        if (tg == 0) exp_q[i].push_back({1'b0, core_data(i, adds[i])});
        else if (tg == 1) exp_q[i].push_back({1'b0, barr_data(bidx_of(adds[i]), adds[i])});
        else exp_q[i].push_back({1'b1, 32'hBADACCE5});
        due_q[i].push_back(cyc + 1);
      end
    end
`ifdef EU_BARR_RR_ARB_EN
    for (int b = 0; b < NB; b++)
      if (win[b] >= 0 && bg[b]) ptr[b] = (win[b] + 1) % NC;
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " core_gnt"}, 64'(core_gnt), 64'd0);
    check({tag, " r_valid"}, 64'(core_r_valid), 64'd0);
    check({tag, " r_opc"}, 64'(core_r_opc), 64'd0);
    check({tag, " r_rdata"}, 64'(|core_r_rdata), 64'd0);
    check({tag, " cu_req"}, 64'(cu_req), 64'd0);
    check({tag, " bu_req"}, 64'(bu_req), 64'd0);
    check({tag, " rr_ptr"}, 64'(dbg_ptr), 64'd0);
  endtask

  initial begin
    logic [NC-1:0][31:0] adds;
    logic [NC-1:0] eg;
    logic [NC-1:0] act;
    logic [NC-1:0] req;
    core_req = '0; core_add = '0; core_wen = '0; core_wdata = '0;
    cu_gnt = '0; bu_gnt = '0;
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    adds = '0;

    // core-slice read
    adds[3] = 32'h010;
    run_cycle(adds, 8'h08, 8'h08, 4'h0, eg);
    run_cycle(adds, 8'h00, 8'h00, 4'h0, eg);

    // three cores contend for barrier 1
    adds[0] = 32'h220; adds[2] = 32'h224; adds[5] = 32'h228;
    repeat (4) run_cycle(adds, 8'b0010_0101, 8'h00, 4'b0010, eg);
    run_cycle(adds, 8'h00, 8'h00, 4'h0, eg);

    // non-existent barrier 7
    adds[1] = 32'h2E0;
    run_cycle(adds, 8'h02, 8'h00, 4'h0, eg);
    run_cycle(adds, 8'h00, 8'h00, 4'h0, eg);

    // parallel grants on barriers 0 and 2
    adds[4] = 32'h204; adds[6] = 32'h248;
    run_cycle(adds, 8'h50, 8'h00, 4'b0101, eg);
    run_cycle(adds, 8'h00, 8'h00, 4'h0, eg);

    // back-to-back: barrier 3, then core slice via trigger code 6
    adds[2] = 32'h260;
    run_cycle(adds, 8'h04, 8'h00, 4'b1000, eg);
    adds[2] = 32'h218;
    run_cycle(adds, 8'h04, 8'h04, 4'h0, eg);
    run_cycle(adds, 8'h00, 8'h00, 4'h0, eg);

    // reset right after a grant drops the pending response
    adds[2] = 32'h200;
    run_cycle(adds, 8'h04, 8'h00, 4'b0001, eg);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    core_req = '0; cu_gnt = '0; bu_gnt = '0;
    for (int i = 0; i < NC; i++) begin
      exp_q[i].delete();
      due_q[i].delete();
    end
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    run_cycle(adds, 8'h00, 8'h00, 4'h0, eg);

    // randomized traffic; a core holds its request until granted
    act = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NC; i++) begin
        if (!act[i] && $urandom_range(0, 1) == 1) begin
          act[i] = 1'b1;
          adds[i] = rand_addr();
        end
      end
      req = act;
      run_cycle(adds, req, req & NC'($urandom), NB'($urandom), eg);
      act = act & ~eg;
    end
    repeat (3) run_cycle(adds, 8'h00, 8'h00, 4'h0, eg);
    for (int i = 0; i < NC; i++)
      check($sformatf("drain core %0d", i), 64'(exp_q[i].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
